// File: rtl/tcdm_bank_arbiter_pkg.sv
// Shared TCDM constants and helpers for the bank arbiter slice.
// Round-robin index sizing and the response-ID pipeline stage type.
package pkg_soc_interconnect;

  // Wide enough for the 16-master maximum; narrower sel values are zero-extended.
  localparam int RR_IDX_MAX_W = 4;

  function automatic int TCDM_BE_WIDTH(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int rr_idx_width(input int nr_masters);
    return (nr_masters > 1) ? $clog2(nr_masters) : 1;
  endfunction

  typedef struct packed {
    logic                    valid;
    logic [RR_IDX_MAX_W-1:0] idx;
  } id_stage_t;

endpackage

// File: rtl/tcdm_bank_arbiter_if.sv
// TCDM bus bundle between N requesters, the arbiter and one bank.
// slave = arbiter view, master = environment (requesters + bank) view.
interface tcdm_bank_arbiter_if import pkg_soc_interconnect::*; #(
  parameter int NR_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = TCDM_BE_WIDTH(DATA_WIDTH);

  logic [NR_MASTERS-1:0]                 mst_req;
  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] mst_add;
  logic [NR_MASTERS-1:0]                 mst_wen;
  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] mst_wdata;
  logic [NR_MASTERS-1:0][BW-1:0]         mst_be;
  logic [NR_MASTERS-1:0]                 mst_gnt;
  logic [NR_MASTERS-1:0]                 mst_r_valid;
  logic [DATA_WIDTH-1:0]                 mst_r_rdata;

  logic                  slv_req;
  logic [ADDR_WIDTH-1:0] slv_add;
  logic                  slv_wen;
  logic [DATA_WIDTH-1:0] slv_wdata;
  logic [BW-1:0]         slv_be;
  logic                  slv_gnt;
  logic                  slv_r_valid;
  logic [DATA_WIDTH-1:0] slv_r_rdata;

  modport slave (
    input  mst_req, mst_add, mst_wen, mst_wdata, mst_be,
           slv_gnt, slv_r_valid, slv_r_rdata,
    output mst_gnt, mst_r_valid, mst_r_rdata,
           slv_req, slv_add, slv_wen, slv_wdata, slv_be
  );

  modport master (
    output mst_req, mst_add, mst_wen, mst_wdata, mst_be,
           slv_gnt, slv_r_valid, slv_r_rdata,
    input  mst_gnt, mst_r_valid, mst_r_rdata,
           slv_req, slv_add, slv_wen, slv_wdata, slv_be
  );
endinterface

// File: rtl/tcdm_bank_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
// Rotate so ptr lands at bit 0, priority-encode, then rotate the offset back.
module tcdm_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          vld
);
  localparam logic [IW:0] NW = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW:0]   j;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Modulo by compare-and-subtract keeps non-power-of-two N correct.
  always_comb begin
    rot = '0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= NW) j = j - NW;
      rot[k] = req[j[IW-1:0]];
    end
    vld = |req;
    off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= NW) ? IW'(sum - NW) : IW'(sum);
  end
endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank among NR_MASTERS requesters,
// with grant-stability lock, fixed-latency response routing and sticky error.
module tcdm_bank_arbiter import pkg_soc_interconnect::*; #(
  parameter int NR_MASTERS   = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tcdm_bank_arbiter_if.slave   bus,
  output logic                 err_o
);
  localparam int IW = rr_idx_width(NR_MASTERS);

  logic [IW-1:0] rr_ptr, lock_idx, pick_idx, sel, ptr_nxt;
  logic          lock, pick_vld, lock_ok, lock_drop;
  logic          slv_req, hs, err_set;
  logic [NR_MASTERS-1:0] gnt, r_valid;

  id_stage_t id_pipe [RESP_LATENCY];
  id_stage_t last;

  tcdm_rr_pick #(.N(NR_MASTERS), .IW(IW)) u_pick (
    .req (bus.mst_req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // A locked master that dropped its request falls back to the RR pick at
  // once, so a non-requesting master is never granted.
  assign lock_ok   = lock &  bus.mst_req[lock_idx];
  assign lock_drop = lock & ~bus.mst_req[lock_idx];
  assign sel       = lock_ok ? lock_idx : pick_idx;
  assign slv_req   = pick_vld & ~rst_i;
  assign hs        = slv_req & bus.slv_gnt;
  assign ptr_nxt   = (sel == IW'(NR_MASTERS-1)) ? '0 : sel + IW'(1);
  assign last      = id_pipe[RESP_LATENCY-1];

  assign bus.slv_req   = slv_req;
  assign bus.slv_add   = bus.mst_add[sel];
  assign bus.slv_wen   = bus.mst_wen[sel];
  assign bus.slv_wdata = bus.mst_wdata[sel];
  assign bus.slv_be    = bus.mst_be[sel];

  always_comb begin
    gnt     = '0;
    r_valid = '0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      gnt[i]     = hs & (sel == IW'(i));
      r_valid[i] = ~rst_i & bus.slv_r_valid & last.valid
                 & (last.idx == RR_IDX_MAX_W'(i));
    end
  end

  assign bus.mst_gnt     = gnt;
  assign bus.mst_r_valid = r_valid;
  assign bus.mst_r_rdata = bus.slv_r_rdata;

  assign err_set = (bus.slv_r_valid ^ last.valid) | lock_drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_o    <= 1'b0;
      for (int s = 0; s < RESP_LATENCY; s++) id_pipe[s] <= '0;
    end else begin
      id_pipe[0] <= '{valid: hs, idx: RR_IDX_MAX_W'(sel)};
      for (int s = 1; s < RESP_LATENCY; s++) id_pipe[s] <= id_pipe[s-1];
      if (hs) begin
        rr_ptr <= ptr_nxt;
        lock   <= 1'b0;
      end else if (slv_req) begin
        lock     <= 1'b1;
        lock_idx <= sel;
      end else begin
        lock <= 1'b0;
      end
      if (err_set) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench: three arbiters (latency 1, 3, 2) share one stimulus stream; a grant
// model predicts handshakes and a per-instance scoreboard checks responses.
module tb_tcdm_bank_arbiter;
  import pkg_soc_interconnect::*;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]         mst_req = '0;
  logic [NM-1:0]         mst_wen = '1;
  logic [NM-1:0][AW-1:0] mst_add = '0;
  logic [NM-1:0][DW-1:0] mst_wdata = '0;
  logic [NM-1:0][3:0]    mst_be = '1;
  logic                  slv_gnt = 1'b0;
  logic                  inj_rv = 1'b0;

  logic [NM-1:0] gnt_all [NI];
  logic [NM-1:0] rv_all  [NI];
  logic [DW-1:0] rdata_all [NI];
  logic [AW-1:0] add_all [NI];
  logic [DW-1:0] wdata_all [NI];
  logic [3:0]    be_all [NI];
  logic          req_all [NI];
  logic          wen_all [NI];
  logic          err_all [NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  function automatic logic [DW-1:0] bank_data(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_lat
    localparam int L = (k == 0) ? 1 : (k == 1) ? 3 : 2;
    tcdm_bank_arbiter_if #(.NR_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [L-1:0]  v_sr;
    logic [DW-1:0] d_sr [L];

    assign bus.mst_req     = mst_req;
    assign bus.mst_add     = mst_add;
    assign bus.mst_wen     = mst_wen;
    assign bus.mst_wdata   = mst_wdata;
    assign bus.mst_be      = mst_be;
    assign bus.slv_gnt     = slv_gnt;
    assign bus.slv_r_valid = v_sr[L-1] | inj_rv;
    assign bus.slv_r_rdata = d_sr[L-1];

    // Bank model: answers every handshake exactly L cycles later.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_sr <= '0;
        for (int j = 0; j < L; j++) d_sr[j] <= '0;
      end else begin
        v_sr[0] <= bus.slv_req & bus.slv_gnt;
        d_sr[0] <= bank_data(bus.slv_add);
        for (int j = 1; j < L; j++) begin
          v_sr[j] <= v_sr[j-1];
          d_sr[j] <= d_sr[j-1];
        end
      end
    end

    tcdm_bank_arbiter #(.NR_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .RESP_LATENCY(L)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave),
      .err_o (err_all[k])
    );

    assign gnt_all[k]   = bus.mst_gnt;
    assign rv_all[k]    = bus.mst_r_valid;
    assign rdata_all[k] = bus.mst_r_rdata;
    assign add_all[k]   = bus.slv_add;
    assign wdata_all[k] = bus.slv_wdata;
    assign be_all[k]    = bus.slv_be;
    assign req_all[k]   = bus.slv_req;
    assign wen_all[k]   = bus.slv_wen;
  end

  typedef struct {
    logic [NM-1:0] vec;
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  sb_t sb_q [NI][$];
  int  ptr = 0, lock_idx = 0, cyc = 0;
  bit  lock = 0, exp_err = 0;
  int  n_chk = 0, n_pass = 0;
  logic [NM-1:0] pend = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // One clock: drive, predict, check mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [NM-1:0] req, input logic gnt,
                      input logic inj, output int g);
    int  sel;
    bit  hs;
    sb_t e;
    logic [NM-1:0] eg;
    rst = r; mst_req = req; slv_gnt = gnt; inj_rv = inj;
    sel = -1;
    if (!r && req != '0) begin
      if (lock && req[lock_idx]) sel = lock_idx;
      else for (int d = 0; d < NM; d++)
        if (sel < 0 && req[(ptr + d) % NM]) sel = (ptr + d) % NM;
    end
    hs = (sel >= 0) && gnt;
    eg = hs ? (NM'(1) << sel) : '0;
    g  = hs ? sel : -1;
    if (r) for (int k = 0; k < NI; k++) sb_q[k].delete();
    if (hs) for (int k = 0; k < NI; k++)
      sb_q[k].push_back('{vec: eg, data: bank_data(mst_add[sel]), due: cyc + lat_of(k)});
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      e.vec = '0; e.data = '0; e.due = 0;
      if (sb_q[k].size() > 0 && sb_q[k][0].due == cyc) e = sb_q[k].pop_front();
      chk($sformatf("L%0d gnt", lat_of(k)), 32'(gnt_all[k]), 32'(eg));
      chk($sformatf("L%0d slv_req", lat_of(k)), 32'(req_all[k]), 32'(sel >= 0));
      if (sel >= 0) begin
        chk($sformatf("L%0d slv_add", lat_of(k)), add_all[k], mst_add[sel]);
        chk($sformatf("L%0d slv_wen", lat_of(k)), 32'(wen_all[k]), 32'(mst_wen[sel]));
        chk($sformatf("L%0d slv_wdata", lat_of(k)), wdata_all[k], mst_wdata[sel]);
        chk($sformatf("L%0d slv_be", lat_of(k)), 32'(be_all[k]), 32'(mst_be[sel]));
      end
      chk($sformatf("L%0d r_valid", lat_of(k)), 32'(rv_all[k]), 32'(e.vec));
      if (e.vec != '0) chk($sformatf("L%0d rdata", lat_of(k)), rdata_all[k], e.data);
      chk($sformatf("L%0d err", lat_of(k)), 32'(err_all[k]), 32'(exp_err));
    end
    @(posedge clk);
    if (r) begin
      ptr = 0; lock = 0; lock_idx = 0; exp_err = 0;
    end else begin
      if (inj) exp_err = 1;
      if (lock && !req[lock_idx]) exp_err = 1;
      if (hs) begin ptr = (sel + 1) % NM; lock = 0; end
      else if (sel >= 0) begin lock = 1; lock_idx = sel; end
      else lock = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, g);
  endtask

  initial begin
    int g;
    @(posedge clk); #1;
    // Reset and idle
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 1'b0, g);
    for (int i = 0; i < NM; i++) begin
      mst_add[i]   = 32'h1C00_0000 + 32'(i * 16);
      mst_wdata[i] = 32'hD000_0000 + 32'(i);
      mst_be[i]    = 4'(4'hF >> i);
      mst_wen[i]   = i[0];
    end
    idle(2);
    // Round-robin with all masters busy: 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) step(1'b0, 4'hF, 1'b1, 1'b0, g);
    idle(4);
    // Lock: masters 1,2 stall, master 0 joins late, selection must not move
    step(1'b1, '0, 1'b0, 1'b0, g);
    for (int i = 0; i < 5; i++) step(1'b0, (i < 2) ? 4'b0110 : 4'b0111, 1'b0, 1'b0, g);
    pend = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, pend, 1'b1, 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle(4);
    // Single read from master 3, checked at each instance's own latency
    step(1'b1, '0, 1'b0, 1'b0, g);
    mst_add[3] = 32'h1C00_8004; mst_wen[3] = 1'b1;
    step(1'b0, 4'b1000, 1'b1, 1'b0, g);
    idle(5);
    // Response with nothing outstanding: sticky error until reset
    step(1'b0, '0, 1'b0, 1'b1, g);
    idle(3);
    step(1'b1, '0, 1'b0, 1'b0, g);
    idle(1);
    // Reset while a request is in flight, then a stray bank response
    step(1'b0, 4'b0001, 1'b1, 1'b0, g);
    step(1'b1, '0, 1'b0, 1'b0, g);
    step(1'b0, '0, 1'b0, 1'b1, g);
    idle(2);
    step(1'b1, '0, 1'b0, 1'b0, g);
    // Random legal traffic: requests held until granted
    pend = '0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]      = 1'b1;
          mst_add[i]   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
          mst_wen[i]   = 1'($urandom_range(0, 1));
          mst_wdata[i] = $urandom;
          mst_be[i]    = 4'($urandom_range(0, 15));
        end
      end
      step(1'b0, pend, ($urandom_range(0, 3) != 0), 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
